// File: rtl/spi_master_driver.sv
// SPI mode-0 master: one MSB-first byte per start/ready handshake, with SCLK
// derived from clk_i by CLK_DIV. All SPI-side outputs are registered.
module spi_master_driver #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       start_i,
    input  logic [7:0] data_in_bi,
    output logic       ready_o,
    output logic       done_o,
    output logic [7:0] data_out_bo,
    output logic       spi_sclk_o,
    output logic       spi_mosi_o,
    input  logic       spi_miso_i,
    output logic       spi_cs_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_HIGH,
        S_LOW,
        S_GAP
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t     state_q;
    logic [7:0] div_q;
    logic [2:0] bitcnt_q;
    logic [6:0] tx_q;
    logic [7:0] rx_q;
    logic [7:0] data_out_q;
    logic       ready_q;
    logic       done_q;
    logic       sclk_q;
    logic       mosi_q;
    logic       cs_q;
    logic       div_end;

    assign div_end = (div_q == DIV_LAST);

    // tx_q holds only the bits not yet on MOSI; bit 7 goes straight to mosi_q at accept.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= S_IDLE;
            div_q      <= '0;
            bitcnt_q   <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            data_out_q <= '0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            cs_q       <= 1'b1;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        tx_q     <= data_in_bi[6:0];
                        rx_q     <= '0;
                        div_q    <= '0;
                        bitcnt_q <= '0;
                        cs_q     <= 1'b0;
                        mosi_q   <= data_in_bi[7];
                        ready_q  <= 1'b0;
                        state_q  <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (div_end) begin
                        div_q   <= '0;
                        sclk_q  <= 1'b1;
                        rx_q    <= {rx_q[6:0], spi_miso_i};
                        state_q <= S_HIGH;
                    end else begin
                        div_q <= div_q + 8'd1;
                    end
                end
                S_HIGH: begin
                    if (div_end) begin
                        div_q   <= '0;
                        sclk_q  <= 1'b0;
                        mosi_q  <= tx_q[6];
                        tx_q    <= {tx_q[5:0], 1'b0};
                        state_q <= S_LOW;
                    end else begin
                        div_q <= div_q + 8'd1;
                    end
                end
                S_LOW: begin
                    if (div_end) begin
                        div_q <= '0;
                        if (bitcnt_q != 3'd7) begin
                            bitcnt_q <= bitcnt_q + 3'd1;
                            sclk_q   <= 1'b1;
                            rx_q     <= {rx_q[6:0], spi_miso_i};
                            state_q  <= S_HIGH;
                        end else begin
                            // Final low phase doubles as CS hold time.
                            cs_q       <= 1'b1;
                            mosi_q     <= 1'b0;
                            data_out_q <= rx_q;
                            done_q     <= 1'b1;
                            state_q    <= S_GAP;
                        end
                    end else begin
                        div_q <= div_q + 8'd1;
                    end
                end
                S_GAP: begin
                    if (div_end) begin
                        div_q   <= '0;
                        ready_q <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        div_q <= div_q + 8'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ready_o     = ready_q;
    assign done_o      = done_q;
    assign data_out_bo = data_out_q;
    assign spi_sclk_o  = sclk_q;
    assign spi_mosi_o  = mosi_q;
    assign spi_cs_o    = cs_q;

endmodule
